// File: rtl/mdio_pkg.sv
// rtl/mdio_pkg.sv - Clause-22 MDIO frame constants, state enum and frame builder.
package mdio_pkg;

    localparam logic [1:0] MDIO_OP_RD = 2'b10;
    localparam logic [1:0] MDIO_OP_WR = 2'b01;
    localparam logic [1:0] MDIO_ST    = 2'b01;
    localparam logic [1:0] MDIO_TA_WR = 2'b10;

    localparam int HDR_BITS  = 14;
    localparam int TA_BITS   = 2;
    localparam int DATA_BITS = 16;
    localparam int PRE_BITS  = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_HDR,
        ST_TA,
        ST_DATA,
        ST_END
    } mdio_state_e;

    // Reads leave TA and DATA as zeros: those bits are never driven (oe=0).
    function automatic logic [31:0] mdio_frame(input logic        rd,
                                               input logic [4:0]  phy,
                                               input logic [4:0]  regad,
                                               input logic [15:0] wdata);
        if (rd)
            return {MDIO_ST, MDIO_OP_RD, phy, regad, 2'b00, 16'h0000};
        else
            return {MDIO_ST, MDIO_OP_WR, phy, regad, MDIO_TA_WR, wdata};
    endfunction

endpackage

// File: rtl/mdio_clk_div.sv
// rtl/mdio_clk_div.sv - Registered MDC divider; restarts from zero whenever run rises.
module mdio_clk_div #(
    parameter int CLK_DIV = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic mdc,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int CW = $clog2(CLK_DIV) + 1;

    if (CLK_DIV < 2) begin : g_bad_div
        $error("mdio_clk_div: CLK_DIV must be >= 2");
    end

    logic [CW-1:0] cnt_q, cnt_d;
    logic          mdc_q, mdc_d;
    logic          wrap;

    assign wrap = run && (cnt_q == CW'(CLK_DIV - 1));

    always_comb begin
        cnt_d = '0;
        mdc_d = 1'b0;
        if (run) begin
            cnt_d = wrap ? '0 : cnt_q + CW'(1);
            mdc_d = mdc_q ^ wrap;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            mdc_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            mdc_q <= mdc_d;
        end
    end

    assign mdc       = mdc_q;
    assign rise_tick = wrap && !mdc_q;
    assign fall_tick = wrap && mdc_q;

endmodule

// File: rtl/mdio_master.sv
// rtl/mdio_master.sv - Clause-22 MDIO transaction engine (valid/ready command in, read data out).
// Optional MDIO_PREAMBLE_EN adds a 32-bit all-ones preamble before ST.
module mdio_master
    import mdio_pkg::*;
#(
    parameter int CLK_DIV = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [4:0]  cmd_phy,
    input  logic [4:0]  cmd_reg,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        busy,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);

    mdio_state_e state_q, state_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [31:0] tx_q, tx_d;
    logic [15:0] rx_q, rx_d;
    logic [15:0] rsp_rdata_q, rsp_rdata_d;
    logic        rd_q, rd_d;
    logic        mdio_o_q, mdio_o_d;
    logic        oe_q, oe_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        run, rise_tick, fall_tick;
    logic [31:0] frame;

    assign run   = (state_q != ST_IDLE);
    assign frame = mdio_frame(cmd_op, cmd_phy, cmd_reg, cmd_wdata);

    mdio_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .mdc       (mdc),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        rsp_rdata_d = rsp_rdata_q;
        rd_d        = rd_q;
        mdio_o_d    = mdio_o_q;
        oe_d        = oe_q;
        rsp_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    rd_d      = cmd_op;
                    bit_cnt_d = '0;
                    oe_d      = 1'b1;
`ifdef MDIO_PREAMBLE_EN
                    state_d   = ST_PRE;
                    mdio_o_d  = 1'b1;
                    tx_d      = frame;
`else
                    state_d   = ST_HDR;
                    mdio_o_d  = frame[31];
                    tx_d      = {frame[30:0], 1'b0};
`endif
                end
            end
`ifdef MDIO_PREAMBLE_EN
            ST_PRE: begin
                if (fall_tick) begin
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    if (bit_cnt_q == 6'(PRE_BITS - 1)) begin
                        state_d   = ST_HDR;
                        bit_cnt_d = '0;
                        mdio_o_d  = tx_q[31];
                        tx_d      = {tx_q[30:0], 1'b0};
                    end
                end
            end
`endif
            ST_HDR: begin
                if (fall_tick) begin
                    mdio_o_d  = tx_q[31];
                    tx_d      = {tx_q[30:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    if (bit_cnt_q == 6'(HDR_BITS - 1)) begin
                        state_d   = ST_TA;
                        bit_cnt_d = '0;
                        oe_d      = !rd_q;
                    end
                end
            end
            ST_TA: begin
                if (fall_tick) begin
                    mdio_o_d  = tx_q[31];
                    tx_d      = {tx_q[30:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    if (bit_cnt_q == 6'(TA_BITS - 1)) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
            end
            ST_DATA: begin
                if (rise_tick && rd_q)
                    rx_d = {rx_q[14:0], mdio_i};
                if (fall_tick) begin
                    mdio_o_d  = tx_q[31];
                    tx_d      = {tx_q[30:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    if (bit_cnt_q == 6'(DATA_BITS - 1)) begin
                        state_d   = ST_END;
                        bit_cnt_d = '0;
                        oe_d      = 1'b0;
                        mdio_o_d  = 1'b0;
                    end
                end
            end
            ST_END: begin
                if (fall_tick) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    if (rd_q)
                        rsp_rdata_d = rx_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            rsp_rdata_q <= '0;
            rd_q        <= 1'b0;
            mdio_o_q    <= 1'b0;
            oe_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            rsp_rdata_q <= rsp_rdata_d;
            rd_q        <= rd_d;
            mdio_o_q    <= mdio_o_d;
            oe_q        <= oe_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE) && !rst;
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mdio_o    = mdio_o_q;
    assign mdio_oe   = oe_q;

endmodule
